// File: rtl/result_writeback_unit.sv
// Snapshots the NxN result matrix on start and streams the active n x n block, row-major, to memory.
// Optional single-word stepping is compiled in with the WRITEBACK_STEP_EN macro.
module result_writeback_unit #(
  parameter int WIDTH = 16,
  parameter int N     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef WRITEBACK_STEP_EN
  input  logic                    stepping_enable,
  input  logic                    step,
`endif
  input  logic                    start,
  input  logic signed [WIDTH-1:0] matrix_C [N][N],
  input  logic [11:0]             addr_C,
  input  logic [8:0]              n,
  output logic                    mem_we,
  input  logic                    mem_ready,
  output logic [11:0]             mem_addr,
  output logic signed [WIDTH-1:0] mem_wdata,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [15:0]             words_written
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE, S_ERR} state_t;

  state_t                  state_reg;
  logic [11:0]             base_reg;
  logic [8:0]              n_reg;
  logic [IDX_W-1:0]        row_reg, col_reg;
  logic                    mem_we_reg, busy_reg, done_reg, error_reg;
  logic [11:0]             mem_addr_reg;
  logic signed [WIDTH-1:0] mem_wdata_reg;
  logic [15:0]             words_reg;

  logic                    capture;
  logic [N*N*WIDTH-1:0]    snap_flat;

  assign capture = (state_reg == S_IDLE) && start;

  // One snapshot register per element, flattened row-major for indexed readout.
  for (genvar gi = 0; gi < N * N; gi++) begin : g_snap
    logic signed [WIDTH-1:0] elem_reg;
    always_ff @(posedge clk) begin
      if (capture) elem_reg <= matrix_C[gi / N][gi % N];
    end
    assign snap_flat[gi*WIDTH +: WIDTH] = elem_reg;
  end

  logic [8:0]       last_idx;
  logic             col_last, row_last;
  logic [IDX_W-1:0] row_next, col_next;
  logic [WIDTH-1:0] word_next;

  assign last_idx = n_reg - 9'd1;
  assign col_last = (9'(col_reg) == last_idx);
  assign row_last = (9'(row_reg) == last_idx);

  always_comb begin
    row_next = row_reg;
    col_next = col_reg + 1'b1;
    if (col_last) begin
      col_next = '0;
      row_next = row_reg + 1'b1;
    end
  end

  assign word_next = snap_flat[(int'(row_next) * N + int'(col_next)) * WIDTH +: WIDTH];

  // Range check is done 19 bits wide so the end address cannot wrap past 4095.
  logic [18:0] nn_sq, span_end;
  logic        n_legal, job_illegal;

  assign nn_sq       = {10'd0, n_reg} * {10'd0, n_reg};
  assign span_end    = {7'd0, base_reg} + nn_sq - 19'd1;
  assign n_legal     = (n_reg != 9'd0) && (n_reg <= 9'(N));
  assign job_illegal = !n_legal || (span_end > 19'd4095);

  logic step_go, step_mode;
`ifdef WRITEBACK_STEP_EN
  logic step_d_reg;
  always_ff @(posedge clk) begin
    if (rst) step_d_reg <= 1'b0;
    else     step_d_reg <= step;
  end
  assign step_go   = step & ~step_d_reg;
  assign step_mode = stepping_enable;
`else
  assign step_go   = 1'b0;
  assign step_mode = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      base_reg      <= '0;
      n_reg         <= '0;
      row_reg       <= '0;
      col_reg       <= '0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      error_reg     <= 1'b0;
      words_reg     <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            base_reg  <= addr_C;
            n_reg     <= n;
            busy_reg  <= 1'b1;
            state_reg <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (job_illegal) begin
            busy_reg  <= 1'b0;
            error_reg <= 1'b1;
            state_reg <= S_ERR;
          end else begin
            error_reg     <= 1'b0;
            words_reg     <= '0;
            row_reg       <= '0;
            col_reg       <= '0;
            mem_addr_reg  <= base_reg;
            mem_wdata_reg <= snap_flat[0 +: WIDTH];
            mem_we_reg    <= 1'b1;
            state_reg     <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (mem_we_reg && mem_ready) begin
            words_reg <= words_reg + 16'd1;
            if (row_last && col_last) begin
              mem_we_reg <= 1'b0;
              busy_reg   <= 1'b0;
              done_reg   <= 1'b1;
              state_reg  <= S_DONE;
            end else begin
              row_reg       <= row_next;
              col_reg       <= col_next;
              mem_addr_reg  <= mem_addr_reg + 12'd1;
              mem_wdata_reg <= word_next;
              if (step_mode) mem_we_reg <= 1'b0;
            end
          end else if (!mem_we_reg && (step_go || !step_mode)) begin
            // Parked between stepped words: release the next one.
            mem_we_reg <= 1'b1;
          end
        end
        S_DONE: begin
          done_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
        S_ERR: begin
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign mem_we        = mem_we_reg;
  assign mem_addr      = mem_addr_reg;
  assign mem_wdata     = mem_wdata_reg;
  assign busy          = busy_reg;
  assign done          = done_reg;
  assign error         = error_reg;
  assign words_written = words_reg;

endmodule

// File: tb/tb_result_writeback_unit.sv
// Self-checking bench for result_writeback_unit: directed and random jobs against a row-major
// expected-write list; also exercises the WRITEBACK_STEP_EN build when that macro is defined.
module tb_result_writeback_unit;
  localparam int WIDTH = 16;
  localparam int N     = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst, start, mem_ready;
  logic signed [WIDTH-1:0] matrix_C [N][N];
  logic [11:0]             addr_C;
  logic [8:0]              n;
  logic                    mem_we, busy, done, error;
  logic [11:0]             mem_addr;
  logic signed [WIDTH-1:0] mem_wdata;
  logic [15:0]             words_written;
`ifdef WRITEBACK_STEP_EN
  logic stepping_enable, step;
`endif

  int checks = 0;
  int errors = 0;

  result_writeback_unit #(.WIDTH(WIDTH), .N(N)) dut (
    .clk(clk),
    .rst(rst),
`ifdef WRITEBACK_STEP_EN
    .stepping_enable(stepping_enable),
    .step(step),
`endif
    .start(start),
    .matrix_C(matrix_C),
    .addr_C(addr_C),
    .n(n),
    .mem_we(mem_we),
    .mem_ready(mem_ready),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .busy(busy),
    .done(done),
    .error(error),
    .words_written(words_written)
  );

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic scramble_inputs();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        matrix_C[i][j] = WIDTH'($urandom);
    addr_C = 12'($urandom);
    n      = 9'($urandom);
  endtask

  // Drives one job and checks every cycle against the expected row-major write list.
  task automatic run_job(input int base, input int nn, input int stall_at, input int stall_len,
                         input int abort_at, input bit use_formula);
    logic signed [WIDTH-1:0] mat [N][N];
    logic [11:0]             exp_addr [$];
    logic signed [WIDTH-1:0] exp_data [$];
    bit legal, done_seen, aborted;
    int off, widx, stalls, total;

    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        mat[i][j] = use_formula ? WIDTH'(10 * i + j - 5) : WIDTH'($urandom);
    legal = (nn >= 1) && (nn <= N) && (base + nn * nn - 1 <= 4095);
    total = legal ? nn * nn : 0;
    for (int i = 0; i < total / (nn > 0 ? nn : 1) && legal; i++)
      for (int j = 0; j < nn; j++) begin
        exp_addr.push_back(12'(base + i * nn + j));
        exp_data.push_back(mat[i][j]);
      end

    @(negedge clk);
    matrix_C  = mat;
    addr_C    = 12'(base);
    n         = 9'(nn);
    start     = 1'b1;
    mem_ready = 1'b1;
    @(posedge clk);
    off = 0; widx = 0; stalls = 0; done_seen = 0; aborted = 0;

    for (int c = 0; c < 200 && !done_seen && !aborted; c++) begin
      @(negedge clk);
      off++;
      scramble_inputs();
      start = legal && (off == 4);
      if (abort_at >= 0 && widx == abort_at) begin
        rst = 1'b1; start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort_we", mem_we, 0);
        check("abort_busy", busy, 0);
        check("abort_words", words_written, 0);
        check("abort_done", done, 0);
        aborted = 1;
      end else if (!legal) begin
        mem_ready = 1'b1;
        check("err_no_we", mem_we, 0);
        check("err_no_done", done, 0);
        if (off == 3) begin
          check("err_flag", error, 1);
          check("err_busy", busy, 0);
        end
        if (off == 6) begin
          check("err_sticky", error, 1);
          done_seen = 1;
        end
      end else begin
        if (mem_we && widx == stall_at && stalls < stall_len) begin
          mem_ready = 1'b0;
          stalls++;
        end else begin
          mem_ready = 1'b1;
        end
        if (done) begin
          check("done_cycle", off, 2 + total + stalls);
          check("done_words", words_written, total);
          check("done_count", widx, total);
          done_seen = 1;
        end else begin
          check("busy", busy, 1);
          if (off == 2) check("err_cleared", error, 0);
          check("we", mem_we, (off == 1) ? 0 : 1);
          if (mem_we && widx < total) begin
            check("addr", mem_addr, exp_addr[widx]);
            check("wdata", mem_wdata, exp_data[widx]);
            if (mem_ready) widx++;
          end
        end
      end
    end
    start = 1'b0;
    mem_ready = 1'b1;
    if (legal && !aborted) begin
      if (!done_seen) check("done_timeout", 0, 1);
      @(negedge clk);
      check("post_done", done, 0);
      check("post_busy", busy, 0);
      check("post_we", mem_we, 0);
      @(negedge clk);
      check("post_we2", mem_we, 0);
    end
    $display("job base=%0d n=%0d legal=%0d stalls=%0d accepted=%0d aborted=%0d",
             base, nn, legal, stalls, widx, aborted);
  endtask

  initial begin
    int base, nn;
    rst = 1'b1; start = 1'b0; mem_ready = 1'b1;
`ifdef WRITEBACK_STEP_EN
    stepping_enable = 1'b0; step = 1'b0;
`endif
    scramble_inputs();

    // Reset held 2 cycles with random inputs, including start.
    @(negedge clk); start = 1'b1; mem_ready = 1'($urandom);
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_words", words_written, 0);
    rst = 1'b0; start = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 0);
    $display("reset sequence complete");

    run_job(32, 4, -1, 0, -1, 1);
    run_job(100, 2, -1, 0, -1, 0);
    run_job(32, 4, 5, 3, -1, 1);
    run_job(0, 0, -1, 0, -1, 0);
    run_job(10, 5, -1, 0, -1, 0);
    run_job(4090, 4, -1, 0, -1, 0);
    run_job(4080, 4, 2, 1, -1, 0);
    run_job(500, 1, -1, 0, -1, 0);
    run_job(64, 4, -1, 0, 7, 0);
    run_job(64, 4, -1, 0, -1, 0);

    for (int t = 0; t < 10; t++) begin
      nn = $urandom_range(0, 5);
      if ($urandom_range(0, 3) == 0) base = (4096 - nn * nn + $urandom_range(0, 1)) & 4095;
      else base = $urandom_range(0, 4095);
      run_job(base, nn, $urandom_range(0, 15), $urandom_range(0, 3), -1, 0);
    end

`ifdef WRITEBACK_STEP_EN
    begin
      int cnt;
      cnt = 0;
      @(negedge clk);
      stepping_enable = 1'b1;
      scramble_inputs();
      addr_C = 12'd200; n = 9'd4; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 8; c++) begin
        if (mem_we && mem_ready) begin check("step_addr", mem_addr, 200 + cnt); cnt++; end
        @(negedge clk);
      end
      check("step_first", cnt, 1);
      for (int p = 0; p < 3; p++) begin
        step = 1'b1;
        for (int c = 0; c < 5; c++) begin
          if (mem_we && mem_ready) begin check("step_addr", mem_addr, 200 + cnt); cnt++; end
          @(negedge clk);
          step = 1'b0;
        end
      end
      check("step_words", cnt, 4);
      check("step_ww", words_written, 4);
      stepping_enable = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
        if (mem_we && mem_ready) begin check("step_addr", mem_addr, 200 + cnt); cnt++; end
        @(negedge clk);
      end
      check("step_done", done, 1);
      check("step_total", cnt, 16);
      $display("step job base=200 n=4 accepted=%0d", cnt);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
